// File: rtl/core_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// core_phase_sequencer_if
// Bundles the control requests and phase/status outputs of the phase
// sequencer. The clock and reset are not part of the bundle.
//   master : drives run/step/halt requests and wait inputs, observes status
//   slave  : the sequencer itself
// Signals:
//   run_req, step_req, halt_req   run/step/halt control requests
//   mem_wait, wb_wait             stretch MEM_READ / WRITEBACK while high
//   sig_read_im .. sig_write_back one-hot phase strobes
//   halted, timeout_err, phase    status
//   cycle_count, instret          32-bit wrapping counters
// ----------------------------------------------------------------------------
interface core_phase_sequencer_if;
    logic        run_req;
    logic        step_req;
    logic        halt_req;
    logic        mem_wait;
    logic        wb_wait;
    logic        sig_read_im;
    logic        sig_data_read;
    logic        sig_compute;
    logic        sig_write_back;
    logic        halted;
    logic        timeout_err;
    logic [2:0]  phase;
    logic [31:0] cycle_count;
    logic [31:0] instret;

    modport master (
        output run_req, step_req, halt_req, mem_wait, wb_wait,
        input  sig_read_im, sig_data_read, sig_compute, sig_write_back,
        input  halted, timeout_err, phase, cycle_count, instret
    );

    modport slave (
        input  run_req, step_req, halt_req, mem_wait, wb_wait,
        output sig_read_im, sig_data_read, sig_compute, sig_write_back,
        output halted, timeout_err, phase, cycle_count, instret
    );
endinterface

// File: rtl/core_phase_sequencer.sv
// ----------------------------------------------------------------------------
// core_phase_sequencer
// Multi-cycle phase controller for the single-issue core. Walks
// FETCH -> MEM_READ -> COMPUTE -> WRITEBACK, stretching MEM_READ and
// WRITEBACK while the corresponding wait input is high (bounded by
// STALL_TIMEOUT), and provides run / halt / single-step control plus cycle
// and retired-instruction counters.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of core_phase_sequencer_if (requests in, strobes and
//        status out; every output comes straight from a flop)
// ----------------------------------------------------------------------------
module core_phase_sequencer #(
    parameter int unsigned STALL_TIMEOUT = 1023,
    parameter bit          START_HALTED  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    core_phase_sequencer_if.slave  bus
);

    localparam int WAIT_W = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STALL_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1'b1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(1'b0);

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_MEM_READ  = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              halt_pending_q, halt_pending_d;
    logic              step_mode_q, step_mode_d;
    logic              timeout_err_q, timeout_err_d;
    logic              step_sync1_q, step_sync1_d;
    logic              step_sync2_q, step_sync2_d;
    logic              step_prev_q, step_prev_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       instret_q, instret_d;
    logic              sig_read_im_q, sig_read_im_d;
    logic              sig_data_read_q, sig_data_read_d;
    logic              sig_compute_q, sig_compute_d;
    logic              sig_write_back_q, sig_write_back_d;
    logic              halted_q, halted_d;

    logic wait_sel_s;
    logic timed_out_s;
    logic stall_s;
    logic forced_s;
    logic step_edge_s;
    logic retire_s;

    // Select the wait input that applies to the current phase and derive stall/force.
    always_comb begin
        case (state_q)
            ST_MEM_READ:  wait_sel_s = bus.mem_wait;
            ST_WRITEBACK: wait_sel_s = bus.wb_wait;
            default:      wait_sel_s = 1'b0;
        endcase
        timed_out_s  = (wait_cnt_q == WAIT_LIMIT);
        // Once the limit is reached the wait input is ignored and the phase is forced on.
        stall_s      = wait_sel_s & ~timed_out_s;
        forced_s     = wait_sel_s & timed_out_s;
        step_edge_s  = step_sync2_q & ~step_prev_q;
        step_sync1_d = bus.step_req;
        step_sync2_d = step_sync1_q;
        step_prev_d  = step_sync2_q;
    end

    // Next-state logic, wait counter, halt/step bookkeeping and sticky timeout flag.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        step_mode_d   = step_mode_q;
        timeout_err_d = timeout_err_q;
        retire_s      = 1'b0;
        if (state_q != ST_HALT) begin
            halt_pending_d = halt_pending_q | bus.halt_req;
        end else begin
            halt_pending_d = halt_pending_q;
        end

        case (state_q)
            ST_BOOT: begin
                if (START_HALTED || !bus.run_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d    = ST_MEM_READ;
                wait_cnt_d = WAIT_ZERO;
            end
            ST_MEM_READ: begin
                if (stall_s) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                state_d    = ST_WRITEBACK;
                wait_cnt_d = WAIT_ZERO;
            end
            ST_WRITEBACK: begin
                if (stall_s) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    retire_s = 1'b1;
                    // halt_req is looked at directly so a request on the last cycle still wins.
                    if (halt_pending_q || bus.halt_req || step_mode_q || !bus.run_req) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                // A step edge beats a concurrent halt_req; step_mode brings us back here.
                if (step_edge_s) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b1;
                end else if (bus.run_req && !bus.halt_req) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (forced_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_d;
        end

        if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
            halt_pending_d = 1'b0;
            step_mode_d    = 1'b0;
        end else begin
            halt_pending_d = halt_pending_d;
        end
    end

    // Counters and output decode; strobes are registered from the next state.
    always_comb begin
        if ((state_q != ST_BOOT) && (state_q != ST_HALT)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end
        if (retire_s) begin
            instret_d = instret_q + 32'd1;
        end else begin
            instret_d = instret_q;
        end
        sig_read_im_d    = (state_d == ST_FETCH);
        sig_data_read_d  = (state_d == ST_MEM_READ);
        sig_compute_d    = (state_d == ST_COMPUTE);
        sig_write_back_d = (state_d == ST_WRITEBACK);
        halted_d         = (state_d == ST_HALT);
    end

    // State, synchronizer, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            wait_cnt_q       <= WAIT_ZERO;
            halt_pending_q   <= 1'b0;
            step_mode_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
            step_sync1_q     <= 1'b0;
            step_sync2_q     <= 1'b0;
            step_prev_q      <= 1'b0;
            cycle_count_q    <= 32'd0;
            instret_q        <= 32'd0;
            sig_read_im_q    <= 1'b0;
            sig_data_read_q  <= 1'b0;
            sig_compute_q    <= 1'b0;
            sig_write_back_q <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            halt_pending_q   <= halt_pending_d;
            step_mode_q      <= step_mode_d;
            timeout_err_q    <= timeout_err_d;
            step_sync1_q     <= step_sync1_d;
            step_sync2_q     <= step_sync2_d;
            step_prev_q      <= step_prev_d;
            cycle_count_q    <= cycle_count_d;
            instret_q        <= instret_d;
            sig_read_im_q    <= sig_read_im_d;
            sig_data_read_q  <= sig_data_read_d;
            sig_compute_q    <= sig_compute_d;
            sig_write_back_q <= sig_write_back_d;
            halted_q         <= halted_d;
        end
    end

    assign bus.sig_read_im    = sig_read_im_q;
    assign bus.sig_data_read  = sig_data_read_q;
    assign bus.sig_compute    = sig_compute_q;
    assign bus.sig_write_back = sig_write_back_q;
    assign bus.halted         = halted_q;
    assign bus.timeout_err    = timeout_err_q;
    assign bus.phase          = state_q;
    assign bus.cycle_count    = cycle_count_q;
    assign bus.instret        = instret_q;

endmodule
